mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator-side controller for the 16-bit byte-addressed data memory, which has combinational reads, writes on the rising edge, and no concurrent read and write.
- Accepts load/store requests from the datapath over a valid/ready handshake. Drives the memory's enable, wr, addr and data_in pins.
- Supports word and byte accesses. Byte stores are done as read-modify-write. Returns the load data or an alignment error over a one-cycle response strobe.

Parameters:
- ADDR_WIDTH, 16: byte-address width. Must match the memory's ADDR_WIDTH.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_wr  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_sext  in  1  byte load only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  16  store data. For a byte store only bits [7:0] are used.
- resp_valid  out  1  one-cycle completion strobe.
- resp_rdata  out  16  load result. Holds 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: unaligned word access, nothing performed.
- mem_en  out  1  to memory enable.
- mem_wr  out  1  to memory wr.
- mem_addr  out  ADDR_WIDTH  to memory addr. Bit 0 is always driven 0.
- mem_wdata  out  16  to memory data_in.
- mem_rdata  in  16  from memory data_out. Valid combinationally while mem_en=1 and mem_wr=0.

Behaviour:
- Reset: state=IDLE. Request registers, resp_valid, resp_err, resp_rdata, mem_en, mem_wr, mem_addr and mem_wdata all 0.
- req_ready = (state==IDLE) & ~rst. A request is accepted on any edge where req_valid & req_ready. All request fields are latched at acceptance.
- Byte lanes (little-endian): addr[0]=0 selects bits [7:0], addr[0]=1 selects bits [15:8].
- Memory pins are decoded from state only. mem_en=1 only in RD and WR. mem_wr=1 only in WR. mem_addr = {latched addr[ADDR_WIDTH-1:1], 1'b0}.
- mem_en and mem_wr are never both asserted for a read cycle in the same state, so there is no concurrent read/write.
- States: IDLE, RD, WR, DONE.
- IDLE, on accept:
  - Unaligned word access (req_byte=0 & req_addr[0]=1) -> DONE with err.
  - Load, or byte store -> RD.
  - Word store -> WR.
- RD:
  - Capture mem_rdata into the word register.
  - Load -> DONE, with the result formed at this edge:
    - Word load: the full word.
    - Byte load: the selected lane, zero- or sign-extended to 16 bits.
  - Byte store -> WR.
- WR:
  - Word store: mem_wdata = latched wdata.
  - Byte store: mem_wdata = captured word with the selected lane replaced by wdata[7:0].
  - Always -> DONE.
- DONE:
  - resp_valid=1 for exactly one cycle. resp_err and resp_rdata are valid in this cycle.
  - Next state IDLE.
  - resp_rdata returns to 0 and resp_err to 0 in IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - Error: 1 cycle.
  - Word store: 2 cycles.
  - Load: 2 cycles.
  - Byte store: 3 cycles.
- Throughput: req_ready returns in the cycle after DONE. There is no back-to-back overlap.
- req_valid while not ready is ignored. The requester must hold its request until accepted.
- Reset mid-operation:
  - FSM goes to IDLE at the sampling edge and the transaction is discarded with no response.
  - A byte store reset while in RD never issues its write.
  - Reset sampled in WR still has mem_en/mem_wr high for that cycle, but the memory ignores writes while rst is high.
- Address wrap: none. The top word address 2^(ADDR_WIDTH-1)-1 is accessed normally.

Decomposition:
- Shared package mem_pkg:
  - State encoding localparams IDLE=2'd0, RD=2'd1, WR=2'd2, DONE=2'd3.
  - Lane-select constants LANE_LO=1'b0, LANE_HI=1'b1.
- One sub-module: byte_lane_merge (combinational).
  - Inputs: word, byte, lane.
  - Outputs: merged word for stores, and extracted/extended byte for loads.
  - Shared by the RD and WR paths.

Test Plan:
- Word store addr 0x0010, wdata 0xBEEF -> WR cycle drives mem_en=1, mem_wr=1, mem_addr=0x0010, mem_wdata=0xBEEF. resp_valid 2 cycles after accept, resp_err=0.
- Word load 0x0010 after the above -> RD cycle has mem_en=1, mem_wr=0. resp_rdata=0xBEEF at resp_valid.
- Byte store addr 0x0011, wdata 0x0012 over word 0xBEEF -> RD then WR with mem_wdata=0x12EF. resp_valid 3 cycles after accept. A following word load returns 0x12EF.
- Byte load 0x0010 with req_sext=1 over 0x12EF -> resp_rdata=0xFFEF. With req_sext=0 -> 0x00EF. Byte load 0x0011 with sext=1 -> 0x0012.
- Word load addr 0x0013 -> resp_valid 1 cycle after accept, resp_err=1, resp_rdata=0. mem_en is never asserted.
- rst=1 for one cycle while in RD of a byte store to 0x0010 -> no WR cycle, no resp_valid, req_ready=1 the cycle after reset drops. A word load then returns the unchanged word.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the data-memory access controller:
//                FSM state encoding and byte-lane select constants.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RD   = RD,
    ST_WR   = WR,
    ST_DONE = DONE
  } state_t;

  // Little-endian byte lanes: addr[0]=0 -> [7:0], addr[0]=1 -> [15:8]
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Request/response handshake plus data-memory pins.
//                slave  = controller side, master = datapath/memory side.
//  Ports       : req_* (request), resp_* (response strobe), mem_* (memory)
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic                  req_byte;
  logic                  req_sext;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [15:0]           req_wdata;
  logic                  resp_valid;
  logic [15:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_byte, req_sext, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_byte, req_sext, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl_byte_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_merge
//  Description : Combinational byte-lane helper. Inserts a byte into a word
//                (store merge) and extracts/extends a byte (load).
//  Ports       : word_i   16-bit source word
//                byte_i   byte to insert
//                lane_i   lane select (LANE_LO / LANE_HI)
//                sext_i   1 = sign-extend extracted byte
//                merged_o word with selected lane replaced by byte_i
//                ext_o    selected lane zero/sign-extended to 16 bits
//  Revision    : 1.0  initial release
// ============================================================================
module byte_lane_merge
  import mem_pkg::*;
(
  input  logic [15:0] word_i,
  input  logic [7:0]  byte_i,
  input  logic        lane_i,
  input  logic        sext_i,
  output logic [15:0] merged_o,
  output logic [15:0] ext_o
);

  logic [7:0] sel;

  always_comb begin
    sel      = (lane_i == LANE_LO) ? word_i[7:0] : word_i[15:8];
    merged_o = (lane_i == LANE_HI) ? {byte_i, word_i[7:0]} : {word_i[15:8], byte_i};
    ext_o    = sext_i ? {{8{sel[7]}}, sel} : {8'h00, sel};
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Initiator-side controller for a 16-bit byte-addressed data
//                memory. Word/byte loads and stores; byte stores are done as
//                read-modify-write. One-cycle response strobe with error flag
//                for unaligned word accesses.
//  Ports       : clk, rst (sync, active high), bus (mem_access_ctrl_if.slave)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  wr_q,    wr_d;
  logic                  byte_q,  byte_d;
  logic                  sext_q,  sext_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           word_q,  word_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  err_q,   err_d;

  logic [15:0] lane_word;
  logic [15:0] merged;
  logic [15:0] ext;

  // Single lane helper serves both paths: in RD it sees the live memory
  // word (load extraction), in WR the captured word (store merge).
  assign lane_word = (state_q == ST_RD) ? bus.mem_rdata : word_q;

  byte_lane_merge u_lane (
    .word_i   (lane_word),
    .byte_i   (wdata_q[7:0]),
    .lane_i   (addr_q[0]),
    .sext_i   (sext_q),
    .merged_o (merged),
    .ext_o    (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      sext_q  <= 1'b0;
      wdata_q <= 16'h0;
      word_q  <= 16'h0;
      rdata_q <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      sext_q  <= sext_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    byte_d  = byte_q;
    sext_d  = sext_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        // rst already forces the registers, so ready reduces to IDLE here
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wr_d    = bus.req_wr;
          byte_d  = bus.req_byte;
          sext_d  = bus.req_sext;
          wdata_d = bus.req_wdata;
          rdata_d = 16'h0;
          err_d   = 1'b0;
          if (!bus.req_byte && bus.req_addr[0]) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (!bus.req_wr || bus.req_byte) begin
            state_d = ST_RD;
          end else begin
            state_d = ST_WR;
          end
        end
      end
      ST_RD: begin
        word_d = bus.mem_rdata;
        if (!wr_q) begin
          rdata_d = byte_q ? ext : bus.mem_rdata;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        rdata_d = 16'h0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.resp_valid = (state_q == ST_DONE);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_en     = (state_q == ST_RD) || (state_q == ST_WR);
  assign bus.mem_wr     = (state_q == ST_WR);
  assign bus.mem_addr   = {addr_q[ADDR_WIDTH-1:1], 1'b0};
  assign bus.mem_wdata  = (state_q != ST_WR) ? 16'h0 : (byte_q ? merged : wdata_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Self-checking bench for mem_access_ctrl: directed vector
//                table, mid-operation reset sequence, randomized requests
//                checked against a byte-array reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_access_ctrl_if #(.ADDR_WIDTH(16)) bus ();

  mem_access_ctrl #(.ADDR_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device: combinational read, write on rising edge, writes ignored in reset
  logic [15:0] dmem [0:32767];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr && !rst) dmem[bus.mem_addr[15:1]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = (bus.mem_en && !bus.mem_wr) ? dmem[bus.mem_addr[15:1]] : 16'h0;

  // Reference model: byte-granular memory contents
  logic [7:0] ref_b [int];

  function automatic logic [7:0] getb(input int a);
    return ref_b.exists(a) ? ref_b[a] : 8'h00;
  endfunction

  typedef struct {
    logic        wr;
    logic        byt;
    logic        sext;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [15:0] exp_wword;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Applies the rules to the model; returns expected response and write data
  task automatic model_op(input logic wr, input logic byt, input logic sext,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata, output logic err,
                          output int lat, output logic [15:0] wword);
    int a0;
    logic [7:0] b;
    a0 = int'(addr) & 32'hFFFE;
    rdata = 16'h0; err = 1'b0; wword = 16'h0;
    if (!byt && addr[0]) begin
      err = 1'b1; lat = 1;
    end else if (wr) begin
      if (byt) ref_b[int'(addr)] = wdata[7:0];
      else begin ref_b[a0] = wdata[7:0]; ref_b[a0 + 1] = wdata[15:8]; end
      wword = {getb(a0 + 1), getb(a0)};
      lat = byt ? 3 : 2;
    end else begin
      lat = 2;
      if (byt) begin
        b = getb(int'(addr));
        rdata = (sext && b[7]) ? (16'hFF00 + 16'(b)) : 16'(b);
      end else rdata = {getb(a0 + 1), getb(a0)};
    end
  endtask

  task automatic run_req(input string name, input logic wr, input logic byt, input logic sext,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input logic [15:0] exp_wword);
    int t, lat, nrd, nwr, badaddr, exp_nrd, exp_nwr;
    logic got, err;
    logic [15:0] rdata, wword;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_byte = byt;
    bus.req_sext = sext; bus.req_addr = addr; bus.req_wdata = wdata;
    t = 0;
    while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
    chk({name, " ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    got = 1'b0; lat = 0; nrd = 0; nwr = 0; badaddr = 0;
    err = 1'b0; rdata = 16'h0; wword = 16'h0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        if (bus.mem_addr !== {addr[15:1], 1'b0}) badaddr++;
        if (bus.mem_wr) begin nwr++; wword = bus.mem_wdata; end
        else nrd++;
      end
      if (bus.resp_valid) begin got = 1'b1; lat = c; rdata = bus.resp_rdata; err = bus.resp_err; end
    end
    exp_nrd = exp_err ? 0 : ((!wr || byt) ? 1 : 0);
    exp_nwr = (exp_err || !wr) ? 0 : 1;
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " rdata"}, 32'(rdata), 32'(exp_rdata));
    chk({name, " err"}, 32'(err), 32'(exp_err));
    chk({name, " rd_cycles"}, 32'(nrd), 32'(exp_nrd));
    chk({name, " wr_cycles"}, 32'(nwr), 32'(exp_nwr));
    chk({name, " mem_addr"}, 32'(badaddr), 32'd0);
    if (exp_nwr != 0) chk({name, " mem_wdata"}, 32'(wword), 32'(exp_wword));
    @(negedge clk);
    chk({name, " back_idle"}, {bus.resp_valid, bus.resp_err, bus.req_ready, bus.resp_rdata},
        {1'b0, 1'b0, 1'b1, 16'h0});
  endtask

  vec_t vecs [14];

  initial begin
    logic [15:0] er, ew;
    logic ee;
    int el, nv, nw;
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 32768; i++) dmem[i] = 16'h0;

    //        wr    byt   sext  addr      wdata     rdata     err   lat wword
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 2, 16'hBEEF};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'h0012, 16'h0000, 1'b0, 3, 16'h12EF};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h12EF, 1'b0, 2, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'hFFEF, 1'b0, 2, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h00EF, 1'b0, 2, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 16'h0012, 1'b0, 2, 16'h0000};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0013, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h8001, 16'h0000, 1'b0, 2, 16'h8001};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'hFF80, 1'b0, 2, 16'h0000};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h00A5, 16'h0000, 1'b0, 3, 16'h80A5};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h80A5, 1'b0, 2, 16'h0000};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0021, 16'h1234, 16'h0000, 1'b1, 1, 16'h0000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, 2, 16'h0000};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_byte = 1'b0;
    bus.req_sext = 1'b0; bus.req_addr = 16'h0; bus.req_wdata = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs",
        {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_en, bus.mem_wr, bus.resp_rdata},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", 32'(bus.req_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      model_op(vecs[i].wr, vecs[i].byt, vecs[i].sext, vecs[i].addr, vecs[i].wdata, er, ee, el, ew);
      run_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].byt, vecs[i].sext, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_wword);
    end

    // Reset while a byte store sits in RD: no write, no response
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_byte = 1'b1;
    bus.req_sext = 1'b0; bus.req_addr = 16'h0010; bus.req_wdata = 16'h0055;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst seq in RD", {bus.mem_en, bus.mem_wr}, {1'b1, 1'b0});
    rst = 1'b1;
    @(negedge clk);
    chk("rst seq held", {bus.req_ready, bus.mem_en, bus.mem_wr}, {1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    nv = 0; nw = 0;
    @(negedge clk);
    chk("rst seq ready", 32'(bus.req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      if (bus.resp_valid) nv++;
      if (bus.mem_wr) nw++;
      @(negedge clk);
    end
    chk("rst seq no resp", 32'(nv), 32'd0);
    chk("rst seq no write", 32'(nw), 32'd0);
    model_op(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, er, ee, el, ew);
    run_req("rst seq reload", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h12EF, 1'b0, 2, 16'h0);
    chk("rst seq model", 32'(er), 32'h12EF);

    // Randomized requests against the reference model
    for (int i = 0; i < 150; i++) begin
      logic wr, byt, sext;
      logic [15:0] addr, wdata;
      wr = 1'($urandom_range(0, 1));
      byt = 1'($urandom_range(0, 1));
      sext = 1'($urandom_range(0, 1));
      wdata = 16'($urandom);
      if ($urandom_range(0, 3) == 0) addr = 16'hFFF8 + 16'($urandom_range(0, 7));
      else addr = 16'h0040 + 16'($urandom_range(0, 15));
      if (!byt && addr[0] && $urandom_range(0, 2) != 0) addr[0] = 1'b0;
      model_op(wr, byt, sext, addr, wdata, er, ee, el, ew);
      run_req($sformatf("rnd%0d", i), wr, byt, sext, addr, wdata, er, ee, el, ew);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
